priority_resolver_seq: RTL and testbench

- Registered, parametrised priority resolver for the PIC datapath.
- Generalises the combinational in-service priority mask to NUM_IRQ channels.
- Adds an in-service register, an acknowledge/EOI handshake, rotating priority (automatic and specific) and special mask mode.
- Sits between the request/mask registers and the control logic that drives INT and the acknowledge sequence.

---
 rtl/priority_resolver_seq.sv | 116 +++++++++++
 tb/tb_priority_resolver_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_seq.sv
// Registered, parametrised interrupt priority resolver: in-service tracking, ack/EOI
// handshake, automatic and specific priority rotation, and special mask mode.
module priority_resolver_seq #(
    parameter int NUM_IRQ = 8,
    parameter int LVL_W   = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               special_mask_mode,
    input  logic               auto_rotate,
    input  logic               ack,
    input  logic               eoi,
    input  logic               eoi_specific,
    input  logic [LVL_W-1:0]   eoi_level,
    input  logic               set_priority,
    input  logic [LVL_W-1:0]   priority_level,
    output logic               int_out,
    output logic [LVL_W-1:0]   int_level,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [LVL_W-1:0]   lowest_ptr
);

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    // Rank k of the result holds channel (ptr+1+k) mod NUM_IRQ.
    function automatic logic [NUM_IRQ-1:0] rot_down(input logic [NUM_IRQ-1:0] v,
                                                    input logic [LVL_W-1:0]   ptr);
        logic [2*NUM_IRQ-1:0] d;
        d = {v, v} >> (int'(ptr) + 1);
        return d[NUM_IRQ-1:0];
    endfunction

    function automatic logic [LVL_W-1:0] rank_to_chan(input logic [LVL_W-1:0] ptr,
                                                      input int               k);
        int s;
        s = int'(ptr) + 1 + k;
        if (s >= NUM_IRQ) s = s - NUM_IRQ;
        return LVL_W'(s);
    endfunction

    logic [NUM_IRQ-1:0] req_eff_p0, blk_p0, req_rot_p0, blk_rot_p0, is_rot_p0;
    logic [NUM_IRQ-1:0] is_nxt;
    logic [LVL_W-1:0]   ptr_nxt, win_chan_p0, clr_chan_p0;
    logic               any_elig_p0, any_is_p0, blocked;
    logic               eoi_lvl_ok, prio_lvl_ok;
    int                 win_rank, clr_rank;

    assign eoi_lvl_ok  = int'(eoi_level) < NUM_IRQ;
    assign prio_lvl_ok = int'(priority_level) < NUM_IRQ;

    // Stage 0: rank-domain arbitration against the current in-service set
    always_comb begin
        req_eff_p0  = irq_req & ~irq_mask & ~in_service;
        blk_p0      = special_mask_mode ? (in_service & ~irq_mask) : in_service;
        req_rot_p0  = rot_down(req_eff_p0, lowest_ptr);
        blk_rot_p0  = rot_down(blk_p0, lowest_ptr);
        is_rot_p0   = rot_down(in_service, lowest_ptr);
        blocked     = 1'b0;
        any_elig_p0 = 1'b0;
        any_is_p0   = 1'b0;
        win_rank    = 0;
        clr_rank    = 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (blk_rot_p0[k]) blocked = 1'b1;
            if (req_rot_p0[k] && !blocked && !any_elig_p0) begin
                any_elig_p0 = 1'b1;
                win_rank    = k;
            end
            if (is_rot_p0[k] && !any_is_p0) begin
                any_is_p0 = 1'b1;
                clr_rank  = k;
            end
        end
        win_chan_p0 = rank_to_chan(lowest_ptr, win_rank);
        clr_chan_p0 = rank_to_chan(lowest_ptr, clr_rank);
    end

    // EOI clears use the pre-clock in-service set; an ack set on the same bit wins
    always_comb begin
        is_nxt = in_service;
        if (eoi && any_is_p0)
            is_nxt = is_nxt & ~(ONE << clr_chan_p0);
        if (eoi_specific && eoi_lvl_ok)
            is_nxt = is_nxt & ~(ONE << eoi_level);
        if (ack && any_elig_p0)
            is_nxt = is_nxt | (ONE << win_chan_p0);

        ptr_nxt = lowest_ptr;
        if (set_priority && prio_lvl_ok)
            ptr_nxt = priority_level;
        else if (eoi && auto_rotate && any_is_p0)
            ptr_nxt = clr_chan_p0;
    end

    // Stage 1: registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int_out    <= 1'b0;
            int_level  <= '0;
            spurious   <= 1'b0;
            in_service <= '0;
            lowest_ptr <= LVL_W'(NUM_IRQ - 1);
        end else begin
            int_out    <= any_elig_p0;
            spurious   <= ack && !any_elig_p0;
            in_service <= is_nxt;
            lowest_ptr <= ptr_nxt;
            if (ack)
                int_level <= any_elig_p0 ? win_chan_p0 : lowest_ptr;
        end
    end

endmodule

// File: tb/tb_priority_resolver_seq.sv
// Scoreboard bench for priority_resolver_seq: a rank-based reference model predicts
// every registered output per clock, plus directed checks of the key scenario values.
module tb_priority_resolver_seq;

    localparam int N  = 8;
    localparam int LW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq_req = '0, irq_mask = '0;
    logic          special_mask_mode = 0, auto_rotate = 0;
    logic          ack = 0, eoi = 0, eoi_specific = 0, set_priority = 0;
    logic [LW-1:0] eoi_level = '0, priority_level = '0;
    logic          int_out, spurious;
    logic [LW-1:0] int_level, lowest_ptr;
    logic [N-1:0]  in_service;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          io;
        logic [LW-1:0] lvl;
        logic          sp;
        logic [N-1:0]  is;
        logic [LW-1:0] ptr;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    priority_resolver_seq #(.NUM_IRQ(N), .LVL_W(LW)) dut (
        .clock(clock), .reset_n(reset_n), .irq_req(irq_req), .irq_mask(irq_mask),
        .special_mask_mode(special_mask_mode), .auto_rotate(auto_rotate),
        .ack(ack), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .set_priority(set_priority), .priority_level(priority_level),
        .int_out(int_out), .int_level(int_level), .spurious(spurious),
        .in_service(in_service), .lowest_ptr(lowest_ptr)
    );

    always #5 clock = ~clock;

    function automatic int rnk(int ch, int ptr);
        return (ch - ptr - 1 + 2 * N) % N;
    endfunction

    task automatic model_reset();
        m = '{io: 1'b0, lvl: '0, sp: 1'b0, is: '0, ptr: LW'(N - 1)};
    endtask

    // Predict the outputs after the next rising edge and queue them.
    task automatic predict();
        int bmin, wr, wch, cr, cch, p, el;
        logic [N-1:0] req_eff, blk;
        exp_t nx;
        p = int'(m.ptr);
        req_eff = irq_req & ~irq_mask & ~m.is;
        blk = special_mask_mode ? (m.is & ~irq_mask) : m.is;
        bmin = N; wr = N; wch = 0; cr = N; cch = 0;
        for (int ch = 0; ch < N; ch++)
            if (blk[ch] && rnk(ch, p) < bmin) bmin = rnk(ch, p);
        for (int ch = 0; ch < N; ch++) begin
            if (req_eff[ch] && rnk(ch, p) < bmin && rnk(ch, p) < wr) begin
                wr = rnk(ch, p); wch = ch;
            end
            if (m.is[ch] && rnk(ch, p) < cr) begin
                cr = rnk(ch, p); cch = ch;
            end
        end
        nx = m;
        nx.io = (wr < N);
        nx.sp = ack && (wr == N);
        if (ack) nx.lvl = (wr < N) ? LW'(wch) : m.ptr;
        if (eoi && cr < N) nx.is[cch] = 1'b0;
        el = int'(eoi_level);
        if (eoi_specific && el < N) nx.is[el] = 1'b0;
        if (ack && wr < N) nx.is[wch] = 1'b1;
        if (set_priority && int'(priority_level) < N) nx.ptr = priority_level;
        else if (eoi && auto_rotate && cr < N) nx.ptr = LW'(cch);
        sb.push_back(nx);
        m = nx;
    endtask

    // One clock: queue the prediction, clock, drop pulses, pop and compare.
    task automatic cycle(input string tag);
        exp_t e;
        predict();
        @(posedge clock);
        #1;
        ack = 0; eoi = 0; eoi_specific = 0; set_priority = 0;
        e = sb.pop_front();
        total++;
        if (int_out !== e.io) begin
            bad++; $display("FAIL %s int_out got=%0d want=%0d", tag, int_out, e.io);
        end
        total++;
        if (int_level !== e.lvl) begin
            bad++; $display("FAIL %s int_level got=%0d want=%0d", tag, int_level, e.lvl);
        end
        total++;
        if (spurious !== e.sp) begin
            bad++; $display("FAIL %s spurious got=%0d want=%0d", tag, spurious, e.sp);
        end
        total++;
        if (in_service !== e.is) begin
            bad++; $display("FAIL %s in_service got=%h want=%h", tag, in_service, e.is);
        end
        total++;
        if (lowest_ptr !== e.ptr) begin
            bad++; $display("FAIL %s lowest_ptr got=%0d want=%0d", tag, lowest_ptr, e.ptr);
        end
    endtask

    task automatic test_reset();
        @(posedge clock);
        #1;
        total++;
        if ({int_out, int_level, spurious, in_service, lowest_ptr} !== {1'b0, 4'd0, 1'b0, 8'h00, 4'd7}) begin
            bad++;
            $display("FAIL reset_vals got=%0d/%0d/%0d/%h/%0d want=0/0/0/00/7",
                     int_out, int_level, spurious, in_service, lowest_ptr);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        irq_req = 8'h14;
        cycle("basic_req");
        total++;
        if (int_out !== 1'b1) begin bad++; $display("FAIL basic_int got=%0d want=1", int_out); end
        ack = 1;
        cycle("basic_ack");
        total++;
        if (in_service !== 8'h04 || int_level !== 4'd2) begin
            bad++; $display("FAIL basic_grant got=%h/%0d want=04/2", in_service, int_level);
        end
        cycle("basic_blocked");
        total++;
        if (int_out !== 1'b0) begin bad++; $display("FAIL basic_blocked got=%0d want=0", int_out); end
    endtask

    task automatic test_nested();
        irq_req = irq_req | 8'h01;
        cycle("nest_req");
        total++;
        if (int_out !== 1'b1) begin bad++; $display("FAIL nest_int got=%0d want=1", int_out); end
        ack = 1;
        cycle("nest_ack");
        total++;
        if (in_service !== 8'h05 || int_level !== 4'd0) begin
            bad++; $display("FAIL nest_grant got=%h/%0d want=05/0", in_service, int_level);
        end
        irq_req = 8'h14;
        eoi = 1;
        cycle("nest_eoi");
        total++;
        if (in_service !== 8'h04) begin bad++; $display("FAIL nest_eoi got=%h want=04", in_service); end
    endtask

    task automatic test_rotate();
        irq_req = 8'h08;
        eoi_specific = 1; eoi_level = 4'd2;
        cycle("rot_clear");
        ack = 1;
        cycle("rot_ack3");
        irq_req = 8'h00;
        auto_rotate = 1; eoi = 1;
        cycle("rot_eoi");
        auto_rotate = 0;
        total++;
        if (in_service !== 8'h00 || lowest_ptr !== 4'd3) begin
            bad++; $display("FAIL rot_eoi got=%h/%0d want=00/3", in_service, lowest_ptr);
        end
        irq_req = 8'h11;
        cycle("rot_req");
        ack = 1;
        cycle("rot_ack");
        total++;
        if (int_level !== 4'd4) begin bad++; $display("FAIL rot_grant got=%0d want=4", int_level); end
        irq_req = 8'h00;
        eoi_specific = 1; eoi_level = 4'd4;
        set_priority = 1; priority_level = 4'd7;
        cycle("rot_cleanup");
    endtask

    task automatic test_smm();
        irq_req = 8'h01;
        cycle("smm_req0");
        ack = 1;
        cycle("smm_ack0");
        irq_req = 8'h80; irq_mask = 8'h01; special_mask_mode = 1;
        cycle("smm_req7");
        total++;
        if (int_out !== 1'b1) begin bad++; $display("FAIL smm_int got=%0d want=1", int_out); end
        ack = 1;
        cycle("smm_ack7");
        total++;
        if (int_level !== 4'd7 || in_service !== 8'h81) begin
            bad++; $display("FAIL smm_grant got=%0d/%h want=7/81", int_level, in_service);
        end
        eoi_specific = 1; eoi_level = 4'd7;
        cycle("smm_clr7");
        special_mask_mode = 0;
        cycle("smm_off1");
        cycle("smm_off2");
        total++;
        if (int_out !== 1'b0) begin bad++; $display("FAIL smm_normal got=%0d want=0", int_out); end
        irq_req = 8'h00; irq_mask = 8'h00;
        eoi_specific = 1; eoi_level = 4'd0;
        cycle("smm_cleanup");
    endtask

    task automatic test_spurious();
        irq_req = 8'h00;
        ack = 1;
        cycle("spur_ack");
        total++;
        if (spurious !== 1'b1 || int_level !== 4'd7 || in_service !== 8'h00) begin
            bad++; $display("FAIL spur_pulse got=%0d/%0d/%h want=1/7/00", spurious, int_level, in_service);
        end
        cycle("spur_after");
        total++;
        if (spurious !== 1'b0) begin bad++; $display("FAIL spur_len got=%0d want=0", spurious); end
    endtask

    task automatic test_same_cycle();
        irq_req = 8'h04;
        cycle("same_req");
        ack = 1; eoi_specific = 1; eoi_level = 4'd2;
        cycle("same_ack_eoi");
        total++;
        if (in_service !== 8'h04) begin bad++; $display("FAIL same_setwins got=%h want=04", in_service); end
        set_priority = 1; priority_level = 4'd9;
        cycle("same_badprio");
        total++;
        if (lowest_ptr !== 4'd7) begin bad++; $display("FAIL same_badprio got=%0d want=7", lowest_ptr); end
        irq_req = 8'h01;
        cycle("same_req0");
        ack = 1;
        cycle("same_ack0");
        eoi = 1; eoi_specific = 1; eoi_level = 4'd2;
        cycle("same_dual_eoi");
        total++;
        if (in_service !== 8'h00) begin bad++; $display("FAIL same_dual_eoi got=%h want=00", in_service); end
        ack = 1;
        cycle("same_ack0b");
        auto_rotate = 1; eoi = 1; set_priority = 1; priority_level = 4'd5;
        cycle("same_prio_wins");
        auto_rotate = 0;
        total++;
        if (lowest_ptr !== 4'd5) begin bad++; $display("FAIL same_prio_wins got=%0d want=5", lowest_ptr); end
        irq_req = 8'h00;
        set_priority = 1; priority_level = 4'd7;
        cycle("same_cleanup");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            irq_req           = N'($urandom);
            irq_mask          = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            special_mask_mode = ($urandom_range(0, 3) == 0);
            auto_rotate       = $urandom_range(0, 1) == 1;
            ack               = ($urandom_range(0, 2) == 0);
            eoi               = ($urandom_range(0, 3) == 0);
            eoi_specific      = ($urandom_range(0, 4) == 0);
            eoi_level         = LW'($urandom_range(0, 9));
            set_priority      = ($urandom_range(0, 7) == 0);
            priority_level    = LW'($urandom_range(0, 9));
            cycle("random");
        end
        special_mask_mode = 0; auto_rotate = 0; irq_mask = '0;
    endtask

    task automatic test_reset_mid();
        irq_req = 8'h06;
        ack = 1;
        cycle("mid_ack");
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({int_out, int_level, spurious, in_service, lowest_ptr} !== {1'b0, 4'd0, 1'b0, 8'h00, 4'd7}) begin
            bad++;
            $display("FAIL mid_reset got=%0d/%0d/%0d/%h/%0d want=0/0/0/00/7",
                     int_out, int_level, spurious, in_service, lowest_ptr);
        end
        model_reset();
        #1;
        reset_n = 1'b1;
        irq_req = 8'h00;
        cycle("post_reset");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_nested();
        test_rotate();
        test_smm();
        test_spurious();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
